reg_write_buffer: RTL and testbench

Write-side feeder for the 16-bit `registerQ1` storage register. Accepts words from an upstream producer over a valid/ready handshake and queues them in a small FIFO. Replays them to the register as single-cycle write commands on `write_port_1`/`choice`, optionally paced with a fixed idle gap. Sits directly upstream of the register, with outputs wired 1:1 to its write inputs.

---
 rtl/reg_write_buffer.sv | 137 +++++++++++++
 tb/tb_reg_write_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_buffer.sv
// =============================================================================
// reg_write_buffer: valid/ready FIFO replaying words as paced registerQ1 write
// strobes; REG_WB_STATS_EN adds the write_total counter.  Rev 1.0
// =============================================================================
`default_nettype none

module reg_write_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int GAP    = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         hold,
  output logic [DATA_W-1:0]            write_port_1,
  output logic                         choice,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
`ifdef REG_WB_STATS_EN
  ,
  output logic [15:0]                  write_total
`endif
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH+1);
  // The gap counter only ever holds GAP-1 down to 0.
  localparam int c_GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [c_GAP_W-1:0] c_GAP_LOAD = (GAP > 0) ? c_GAP_W'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [c_GAP_W-1:0]   gap_q, gap_d;
  logic [c_PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [c_CNT_W-1:0]   count_q, count_d;
  logic                 empty_q, full_q;
  logic                 choice_q;
  logic [DATA_W-1:0]    wp_q;
  logic [DATA_W-1:0]    mem_q [DEPTH];

  logic w_push;
  logic w_may_issue;
  logic w_issue;

  assign in_ready = !full_q && !reset;
  assign w_push   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    w_may_issue = 1'b0;
    case (state_q)
      ST_IDLE:  w_may_issue = 1'b1;
      ST_WRITE: begin
        if (GAP == 0) begin
          w_may_issue = 1'b1;
        end else begin
          state_d = ST_GAP;
          gap_d   = c_GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) w_may_issue = 1'b1;
        else             gap_d = gap_q - c_GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    w_issue = w_may_issue && (count_q != '0) && !hold;
    if (w_may_issue) state_d = w_issue ? ST_WRITE : ST_IDLE;
  end

  // No bypass: a push only happens when not full, so the sum never overflows.
  always_comb begin
    count_d = count_q;
    if (w_push && !w_issue)      count_d = count_q + c_CNT_W'(1);
    else if (!w_push && w_issue) count_d = count_q - c_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      gap_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      choice_q <= 1'b0;
      wp_q     <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == c_CNT_W'(DEPTH));
      choice_q <= w_issue;
      if (w_push)  wr_ptr_q <= wr_ptr_q + c_PTR_W'(1);
      if (w_issue) begin
        rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
        wp_q     <= mem_q[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= in_data;
  end

  assign write_port_1 = wp_q;
  assign choice       = choice_q;
  assign count        = count_q;
  assign empty        = empty_q;
  assign full         = full_q;

`ifdef REG_WB_STATS_EN
  logic [15:0] total_q;

  always_ff @(posedge clk) begin
    if (reset)        total_q <= '0;
    else if (w_issue) total_q <= total_q + 16'd1;
  end

  assign write_total = total_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reg_write_buffer.sv
// =============================================================================
// tb_reg_write_buffer: two buffers (GAP 0 and GAP 2) on shared stimulus, checked
// every cycle against a queue model, plus directed literal checks.  Rev 1.0
// =============================================================================
`default_nettype none

module tb_reg_write_buffer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset    = 1'b1;
  logic        in_valid = 1'b1;
  logic        hold     = 1'b0;
  logic [15:0] in_data  = 16'h1234;

  logic [1:0]       rdy_w, choice_w, empty_w, full_w;
  logic [1:0][15:0] wp_w;
  logic [1:0][2:0]  cnt_w;
`ifdef REG_WB_STATS_EN
  logic [1:0][15:0] tot_w;
`endif

  reg_write_buffer #(.DATA_W(16), .DEPTH(DEPTH), .GAP(0)) u_gap0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_w[0]), .hold(hold), .write_port_1(wp_w[0]),
    .choice(choice_w[0]), .count(cnt_w[0]), .empty(empty_w[0]), .full(full_w[0])
`ifdef REG_WB_STATS_EN
    , .write_total(tot_w[0])
`endif
  );

  reg_write_buffer #(.DATA_W(16), .DEPTH(DEPTH), .GAP(2)) u_gap2 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_w[1]), .hold(hold), .write_port_1(wp_w[1]),
    .choice(choice_w[1]), .count(cnt_w[1]), .empty(empty_w[1]), .full(full_w[1])
`ifdef REG_WB_STATS_EN
    , .write_total(tot_w[1])
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, d, act, exp);
    end
  endtask

  // Behavioural model: a word queue per buffer, and the rule that a write may
  // issue only when at least 1+GAP edges have passed since the previous one.
  int          gapv [2] = '{0, 2};
  logic [15:0] mq [2][$];
  logic        exp_choice [2];
  logic [15:0] exp_wp [2];
  int          last_iss [2];
  int          exp_tot [2];
  bit          model_ok = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mq[d].delete();
        exp_choice[d] = 1'b0;
        exp_wp[d]     = 16'h0000;
        last_iss[d]   = -1000;
        exp_tot[d]    = 0;
      end else begin
        bit push, iss;
        push = in_valid && (mq[d].size() < DEPTH);
        iss  = (mq[d].size() > 0) && !hold && (cyc >= last_iss[d] + 1 + gapv[d]);
        if (iss) begin
          exp_wp[d]     = mq[d].pop_front();
          exp_choice[d] = 1'b1;
          last_iss[d]   = cyc;
          exp_tot[d]    = (exp_tot[d] + 1) % 65536;
        end else begin
          exp_choice[d] = 1'b0;
        end
        if (push) mq[d].push_back(in_data);
      end
    end
    if (reset) model_ok = 1;
  end

  logic [15:0] lg_data [2][$];
  int          lg_cyc  [2][$];

  always @(posedge clk) begin
    #1;
    if (model_ok) begin
      for (int d = 0; d < 2; d++) begin
        chk("choice",   d, choice_w[d], exp_choice[d]);
        chk("write_port_1", d, wp_w[d], exp_wp[d]);
        chk("count",    d, cnt_w[d], mq[d].size());
        chk("empty",    d, empty_w[d], mq[d].size() == 0);
        chk("full",     d, full_w[d], mq[d].size() == DEPTH);
        chk("in_ready", d, rdy_w[d], !reset && (mq[d].size() < DEPTH));
`ifdef REG_WB_STATS_EN
        chk("write_total", d, tot_w[d], exp_tot[d]);
`endif
        if (choice_w[d] === 1'b1) begin
          lg_data[d].push_back(wp_w[d]);
          lg_cyc[d].push_back(cyc);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] dt, input logic h, input logic r);
    @(negedge clk);
    in_valid = v;
    in_data  = dt;
    hold     = h;
    reset    = r;
  endtask

  task automatic at_sample;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic clear_logs;
    for (int d = 0; d < 2; d++) begin
      lg_data[d].delete();
      lg_cyc[d].delete();
    end
  endtask

  logic [15:0] fill_w   [5]  = '{16'd32, 16'd241, 16'd73, 16'd16, 16'd25};
  logic [15:0] pace_w   [3]  = '{16'd69, 16'd64, 16'd123};
  logic [15:0] stream_w [10] = '{16'd93, 16'd256, 16'd198, 16'd1, 16'd2,
                                 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};

  initial begin
    // Reset with a word presented: nothing may be stored.
    drive(1'b1, 16'h1234, 1'b0, 1'b1);
    drive(1'b1, 16'h1234, 1'b0, 1'b1);
    at_sample;
    chk("rst_choice", 0, choice_w[0], 1'b0);
    chk("rst_wp",     0, wp_w[0], 16'h0000);
    chk("rst_count",  0, cnt_w[0], 0);
    chk("rst_empty",  0, empty_w[0], 1'b1);
    chk("rst_ready",  0, rdy_w[0], 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    at_sample;
    chk("post_rst_ready", 0, rdy_w[0], 1'b1);
    chk("post_rst_count", 0, cnt_w[0], 0);

    // Single word latency.
    drive(1'b1, 16'd65, 1'b0, 1'b0);
    at_sample;
    chk("single_cnt", 0, cnt_w[0], 1);
    chk("single_pre", 0, choice_w[0], 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    at_sample;
    for (int d = 0; d < 2; d++) begin
      chk("single_choice", d, choice_w[d], 1'b1);
      chk("single_wp",     d, wp_w[d], 16'd65);
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    at_sample;
    chk("single_end_choice", 0, choice_w[0], 1'b0);
    chk("single_end_empty",  0, empty_w[0], 1'b1);
    idle(4);

    // Fill under hold, then drain.
    clear_logs();
    for (int k = 0; k < 4; k++) drive(1'b1, fill_w[k], 1'b1, 1'b0);
    drive(1'b1, 16'd25, 1'b1, 1'b0);
    at_sample;
    chk("fill_count", 0, cnt_w[0], 4);
    chk("fill_full",  0, full_w[0], 1'b1);
    chk("fill_ready", 0, rdy_w[0], 1'b0);
    drive(1'b1, 16'd25, 1'b1, 1'b0);
    at_sample;
    chk("fill_refuse", 0, cnt_w[0], 4);
    drive(1'b1, 16'd25, 1'b0, 1'b0);
    drive(1'b1, 16'd25, 1'b0, 1'b0);
    idle(20);
    for (int d = 0; d < 2; d++) begin
      chk("fill_pulses", d, lg_data[d].size(), 5);
      if (lg_data[d].size() == 5)
        for (int k = 0; k < 5; k++) begin
          chk("fill_order", d, lg_data[d][k], fill_w[k]);
          if (k > 0) chk("fill_spacing", d, lg_cyc[d][k] - lg_cyc[d][k-1], 1 + gapv[d]);
        end
    end

    // Pacing with back-to-back pushes.
    clear_logs();
    for (int k = 0; k < 3; k++) drive(1'b1, pace_w[k], 1'b0, 1'b0);
    idle(15);
    for (int d = 0; d < 2; d++) begin
      chk("pace_pulses", d, lg_data[d].size(), 3);
      if (lg_data[d].size() == 3)
        for (int k = 0; k < 3; k++) begin
          chk("pace_order", d, lg_data[d][k], pace_w[k]);
          if (k > 0) chk("pace_spacing", d, lg_cyc[d][k] - lg_cyc[d][k-1], 1 + gapv[d]);
        end
    end

    // Reset mid-drain.
    clear_logs();
    for (int k = 0; k < 4; k++) drive(1'b1, 16'(11 * (k + 1)), 1'b1, 1'b0);
    for (int k = 0; k < 20 && lg_data[0].size() < 2; k++) begin
      drive(1'b0, 16'h0000, 1'b0, 1'b0);
      at_sample;
    end
    chk("middrain_pulses", 0, lg_data[0].size(), 2);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    at_sample;
    chk("middrain_count", 0, cnt_w[0], 0);
    chk("middrain_empty", 0, empty_w[0], 1'b1);
    clear_logs();
    idle(6);
    for (int d = 0; d < 2; d++) chk("middrain_stale", d, lg_data[d].size(), 0);
    drive(1'b1, 16'd93, 1'b0, 1'b0);
    at_sample;
    chk("fresh_pre", 0, choice_w[0], 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    at_sample;
    chk("fresh_choice", 0, choice_w[0], 1'b1);
    chk("fresh_wp",     0, wp_w[0], 16'd93);
    idle(6);

    // Continuous stream across pointer wrap with hold toggling every 3 cycles.
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    clear_logs();
    begin
      int i = 0;
      int c = 0;
      while (i < 10 && c < 200) begin
        drive(1'b1, stream_w[i], ((c / 3) % 2) == 1, 1'b0);
        #1;
        if (rdy_w[0]) i++;
        c++;
      end
      chk("stream_accept", 0, i, 10);
    end
    idle(30);
    chk("stream_pulses", 0, lg_data[0].size(), 10);
    if (lg_data[0].size() == 10)
      for (int k = 0; k < 10; k++) chk("stream_order", 0, lg_data[0][k], stream_w[k]);
`ifdef REG_WB_STATS_EN
    chk("stream_total", 0, tot_w[0], 10);
`endif

    // Randomized traffic, checked cycle by cycle against the model.
    repeat (600)
      drive($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 2);
    idle(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
